// File: rtl/b_shifter.sv
// b_shifter: registered barrel shifter / rotator.
// Every operation is computed on one right-direction mux cascade. Left-direction
// operations bit-reverse the operand first and bit-reverse the result afterwards.
// Wrap, zero and sign fill are the only differences between the operations.
module b_shifter #(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [AMT_W-1:0] amt,
  input  logic [2:0]       mode,
  output logic [WIDTH-1:0] y,
  output logic             out_valid
);

  typedef enum logic [2:0] {
    MODE_ROR  = 3'b000,
    MODE_ROL  = 3'b001,
    MODE_LSR  = 3'b010,
    MODE_LSL  = 3'b011,
    MODE_ASR  = 3'b100,
    MODE_RSV5 = 3'b101,
    MODE_RSV6 = 3'b110,
    MODE_RSV7 = 3'b111
  } mode_e;

  if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("b_shifter: WIDTH must be a power of two and at least 2");
  end

  function automatic logic [WIDTH-1:0] bitrev(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      r[i] = v[WIDTH-1-i];
    end
    return r;
  endfunction

  logic             op_reverse;
  logic             op_rotate;
  logic             op_sign_fill;
  logic             op_pass;
  logic             fill_bit;
  logic [WIDTH-1:0] pre;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] stg [AMT_W+1];

  // Decode the operation into direction, wrap/fill behaviour and pass-through.
  always_comb begin
    op_reverse   = 1'b0;
    op_rotate    = 1'b0;
    op_sign_fill = 1'b0;
    op_pass      = 1'b0;
    unique case (mode_e'(mode))
      MODE_ROR: op_rotate = 1'b1;
      MODE_ROL: begin
        op_rotate  = 1'b1;
        op_reverse = 1'b1;
      end
      MODE_LSR: ;
      MODE_LSL: op_reverse = 1'b1;
      MODE_ASR: op_sign_fill = 1'b1;
      default:  op_pass = 1'b1;
    endcase
  end

  assign fill_bit = op_sign_fill & a[WIDTH-1];
  assign pre      = op_reverse ? bitrev(a) : a;
  assign stg[0]   = pre;

  // Stage k moves the data right by 2^k positions when amt[k] is set.
  for (genvar k = 0; k < AMT_W; k++) begin : g_stage
    localparam int unsigned D = 1 << k;
    logic [D-1:0]     top;
    logic [WIDTH-1:0] moved;
    assign top        = op_rotate ? stg[k][D-1:0] : {D{fill_bit}};
    assign moved      = {top, stg[k][WIDTH-1:D]};
    assign stg[k+1]   = amt[k] ? moved : stg[k];
  end

  // Undo the bit reversal for left-direction operations; reserved modes pass a.
  always_comb begin
    result = stg[AMT_W];
    if (op_pass) begin
      result = a;
    end else if (op_reverse) begin
      result = bitrev(stg[AMT_W]);
    end
  end

  // Output register: reset wins, a valid request loads y, idle cycles hold y.
  always_ff @(posedge clk) begin
    if (rst) begin
      y         <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        y <= result;
      end
    end
  end

endmodule

// File: tb/tb_b_shifter.sv
// Directed bench for b_shifter with hand-computed expected values.
module tb_b_shifter;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] a;
  logic [2:0] amt;
  logic [2:0] mode;
  logic [7:0] y;
  logic       out_valid;

  int unsigned n_checks;
  int unsigned n_errors;

  b_shifter #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .a        (a),
    .amt      (amt),
    .mode     (mode),
    .y        (y),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request, clock it in and check the registered result.
  task automatic req(input string tag, input logic [7:0] ai, input logic [2:0] ami,
                     input logic [2:0] mi, input logic [7:0] exp);
    a        = ai;
    amt      = ami;
    mode     = mi;
    in_valid = 1'b1;
    step();
    check(tag, y, exp);
    check({tag, "_ov"}, {7'b0, out_valid}, 8'h01);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    in_valid = 1'b1;
    a        = 8'hFF;
    amt      = 3'd0;
    mode     = 3'b000;

    // Reset holds for two cycles despite a valid request.
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_y", y, 8'h00);
      check("rst_ov", {7'b0, out_valid}, 8'h00);
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    step();
    check("post_rst_y", y, 8'h00);
    check("post_rst_ov", {7'b0, out_valid}, 8'h00);

    // Rotate-right sweep, back to back.
    req("ror0", 8'b1101_0110, 3'd0, 3'b000, 8'b1101_0110);
    req("ror1", 8'b1101_0110, 3'd1, 3'b000, 8'b0110_1011);
    req("ror3", 8'b1101_0110, 3'd3, 3'b000, 8'b1101_1010);
    req("ror7", 8'b1101_0110, 3'd7, 3'b000, 8'b1010_1101);

    // Other modes at amt=3.
    req("rol3", 8'b1101_0110, 3'd3, 3'b001, 8'b1011_0110);
    req("lsr3", 8'b1101_0110, 3'd3, 3'b010, 8'b0001_1010);
    req("lsl3", 8'b1101_0110, 3'd3, 3'b011, 8'b1011_0000);
    req("asr3", 8'b1101_0110, 3'd3, 3'b100, 8'b1111_1010);
    req("rsv5", 8'b1101_0110, 3'd3, 3'b101, 8'b1101_0110);
    req("rsv6", 8'b1101_0110, 3'd3, 3'b110, 8'b1101_0110);
    req("rsv7", 8'b1101_0110, 3'd3, 3'b111, 8'b1101_0110);

    // amt=0 is identity for every mode.
    req("rol0", 8'b1001_0011, 3'd0, 3'b001, 8'b1001_0011);
    req("lsl0", 8'b1001_0011, 3'd0, 3'b011, 8'b1001_0011);
    req("asr0", 8'b1001_0011, 3'd0, 3'b100, 8'b1001_0011);

    // Maximum distance and sign fill.
    req("asr7_pos", 8'b0101_0110, 3'd7, 3'b100, 8'b0000_0000);
    req("lsr7_pos", 8'b0101_0110, 3'd7, 3'b010, 8'b0000_0000);
    req("asr7_neg", 8'b1000_0000, 3'd7, 3'b100, 8'b1111_1111);
    req("lsr7_neg", 8'b1000_0000, 3'd7, 3'b010, 8'b0000_0001);
    req("lsl7", 8'b0000_0011, 3'd7, 3'b011, 8'b1000_0000);
    req("rol7", 8'b0000_0011, 3'd7, 3'b001, 8'b1000_0001);

    // Single request, then idle with changing inputs: y must hold.
    req("hold_req", 8'h81, 3'd1, 3'b000, 8'hC0);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a    = 8'($urandom);
      amt  = 3'($urandom_range(7, 0));
      mode = 3'($urandom_range(7, 0));
      step();
      check("hold_y", y, 8'hC0);
      check("hold_ov", {7'b0, out_valid}, 8'h00);
    end

    // Reset in the same cycle as a valid request discards it.
    rst      = 1'b1;
    in_valid = 1'b1;
    a        = 8'b1101_0110;
    amt      = 3'd1;
    mode     = 3'b000;
    step();
    check("midrst_y", y, 8'h00);
    check("midrst_ov", {7'b0, out_valid}, 8'h00);
    rst = 1'b0;
    req("after_rst", 8'h81, 3'd1, 3'b000, 8'hC0);
    in_valid = 1'b0;
    step();
    check("after_rst_idle_ov", {7'b0, out_valid}, 8'h00);
    check("after_rst_idle_y", y, 8'hC0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
